// File: rtl/sobel_window_gen.sv
// sobel_window_gen
// Streaming 3x3 neighbourhood builder that feeds sobel_filter.
// Raster-order pixels arrive one per valid cycle. Two line buffers hold the
// previous two lines. A 3x3 shift register presents the window on P00..P22,
// with Prc meaning row r and column c of the window, and P11 as the center.
// A window is strobed for every interior center of the frame.
module sobel_window_gen #(
  parameter int WIDTH  = 549,
  parameter int HEIGHT = 319,
  parameter int COL_W  = 10,
  parameter int ROW_W  = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [7:0]       in_pix,
  output logic [7:0]       P00,
  output logic [7:0]       P01,
  output logic [7:0]       P02,
  output logic [7:0]       P10,
  output logic [7:0]       P11,
  output logic [7:0]       P12,
  output logic [7:0]       P20,
  output logic [7:0]       P21,
  output logic [7:0]       P22,
  output logic             win_valid,
  output logic [ROW_W-1:0] win_row,
  output logic [COL_W-1:0] win_col,
  output logic             frame_done
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] MIN_COL  = COL_W'(2);
  localparam logic [ROW_W-1:0] MIN_ROW  = ROW_W'(2);

  // Raster position of the next pixel expected in the frame.
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  // Position of the pixel on the inputs. A start-of-frame forces this to (0,0).
  logic [COL_W-1:0] cur_col;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] next_col;
  logic [ROW_W-1:0] next_row;
  logic             at_row_end;
  logic             at_frame_end;
  logic             emit;

  // lb1 holds line r-1 and lb2 holds line r-2, both indexed by column.
  logic [7:0] lb1 [WIDTH];
  logic [7:0] lb2 [WIDTH];
  logic [7:0] lb1_rd;
  logic [7:0] lb2_rd;

  // Resolve the current pixel position, honouring in_sof as an immediate restart.
  always_comb begin
    cur_col = col;
    cur_row = row;
    if (in_sof) begin
      cur_col = '0;
      cur_row = '0;
    end
  end

  // Read the column above the incoming pixel from both line buffers.
  always_comb begin
    lb1_rd = lb1[cur_col];
    lb2_rd = lb2[cur_col];
  end

  // Compute the next raster position and detect line, frame and window events.
  always_comb begin
    at_row_end   = (cur_col == LAST_COL);
    at_frame_end = at_row_end && (cur_row == LAST_ROW);
    next_col     = cur_col + COL_W'(1);
    next_row     = cur_row;
    if (at_row_end) begin
      next_col = '0;
      if (at_frame_end) begin
        next_row = '0;
      end else begin
        next_row = cur_row + ROW_W'(1);
      end
    end
    emit = in_valid && (cur_row >= MIN_ROW) && (cur_col >= MIN_COL);
  end

  // Advance the raster counters on each accepted pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      col <= next_col;
      row <= next_row;
    end
  end

  // Roll the line buffers on every accepted pixel. The contents are not
  // cleared because rows 0 and 1 rewrite every column before row 2 reads it.
  always_ff @(posedge clk) begin
    if (in_valid && !rst) begin
      lb2[cur_col] <= lb1_rd;
      lb1[cur_col] <= in_pix;
    end
  end

  // Shift the 3x3 window left and load the new right column {r-2, r-1, r}.
  always_ff @(posedge clk) begin
    if (rst) begin
      P00 <= '0;
      P01 <= '0;
      P02 <= '0;
      P10 <= '0;
      P11 <= '0;
      P12 <= '0;
      P20 <= '0;
      P21 <= '0;
      P22 <= '0;
    end else if (in_valid) begin
      P00 <= P01;
      P01 <= P02;
      P02 <= lb2_rd;
      P10 <= P11;
      P11 <= P12;
      P12 <= lb1_rd;
      P20 <= P21;
      P21 <= P22;
      P22 <= in_pix;
    end
  end

  // Emit the strobes and the window center. The center coordinates only
  // change when a window is actually produced, so they hold during idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
    end else begin
      win_valid  <= emit;
      frame_done <= in_valid && at_frame_end;
      if (emit) begin
        win_row <= cur_row - ROW_W'(1);
        win_col <= cur_col - COL_W'(1);
      end
    end
  end

endmodule
